// File: rtl/alu_exec_pkg.sv
// Shared types for the alu execute stage: the buffered result record and the
// occupancy encoding of the output buffer.
package alu_exec_pkg;

   localparam int OCC_W = 2;

   typedef enum logic [OCC_W-1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   typedef struct packed {
      logic [31:0] z;
      logic [2:0]  op;
      logic        equal;
      logic        overflow;
      logic        zero;
   } alu_result_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit alu. Op code 3'b111 has no definition and yields z=0.
// The flags are computed for every op:
//   equal    - x equals y
//   overflow - signed overflow, meaningful only for ADD/SUB (0 otherwise)
//   zero     - z is all zeros
`include "alu.svh"

module alu (
   input  logic signed [31:0] x,
   input  logic signed [31:0] y,
   input  logic        [2:0]  op,
   output logic signed [31:0] z,
   output logic               equal,
   output logic               overflow,
   output logic               zero
);

   assign equal = (x == y);

   // Result and overflow selection by op code
   always_comb begin
      z        = '0;
      overflow = 1'b0;
      case (op)
         `ALU_ADD: begin
            z        = x + y;
            overflow = (x[31] == y[31]) && (z[31] != x[31]);
         end
         `ALU_SUB: begin
            z        = x - y;
            overflow = (x[31] != y[31]) && (z[31] != x[31]);
         end
         `ALU_AND: z = x & y;
         `ALU_OR:  z = x | y;
         `ALU_XOR: z = x ^ y;
         `ALU_SLL: z = x << y[4:0];
         `ALU_SRL: z = x >> y[4:0];
         default:  z = '0;
      endcase
      zero = (z == '0);
   end

endmodule

// File: rtl/alu.svh
// Op-code encodings for the combinational alu.
`ifndef ALU_SVH
`define ALU_SVH

`define ALU_ADD 3'b000
`define ALU_SUB 3'b001
`define ALU_AND 3'b010
`define ALU_OR  3'b011
`define ALU_XOR 3'b100
`define ALU_SLL 3'b101
`define ALU_SRL 3'b110

`endif

// File: rtl/alu_skid_buf.sv
// Two-entry in-order result buffer. The head register drives the consumer
// directly; the tail register only fills when a push arrives while the head
// is still waiting. Callers must not push while FULL or pop while EMPTY.
module alu_skid_buf
   import alu_exec_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  alu_result_t din,
   output alu_result_t head,
   output occ_t        occ
);

   if (DEPTH != 2) begin : g_bad_depth
      $error("alu_skid_buf: DEPTH must be 2");
   end

   alu_result_t head_p1;
   alu_result_t tail_p1;
   occ_t        occ_p1;

   // ---- stage p1: buffered results ----
   // Occupancy state machine; head/tail move with it so order is preserved
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_p1  <= OCC_EMPTY;
         head_p1 <= '0;
         tail_p1 <= '0;
      end else begin
         case (occ_p1)
            OCC_EMPTY: begin
               if (push) begin
                  head_p1 <= din;
                  occ_p1  <= OCC_ONE;
               end
            end
            OCC_ONE: begin
               case ({push, pop})
                  2'b10: begin
                     tail_p1 <= din;
                     occ_p1  <= OCC_FULL;
                  end
                  2'b01: occ_p1 <= OCC_EMPTY;
                  2'b11: head_p1 <= din;
                  default: ;
               endcase
            end
            OCC_FULL: begin
               if (pop) begin
                  head_p1 <= tail_p1;
                  occ_p1  <= OCC_ONE;
               end
            end
            default: occ_p1 <= OCC_EMPTY;
         endcase
      end
   end

   assign head = head_p1;
   assign occ  = occ_p1;

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage around the combinational alu. Requests are
// evaluated in the accept cycle and the result record is captured into a
// 2-entry buffer; outputs come from registers only, giving 1-cycle latency.
// Optional feature macro: ALU_EXEC_STICKY_EN (sticky overflow flag).
module alu_exec_stage
   import alu_exec_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [31:0] in_x,
   input  logic signed [31:0] in_y,
   input  logic        [2:0]  in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic        [31:0] out_z,
   output logic        [2:0]  out_op,
   output logic               out_equal,
   output logic               out_overflow,
   output logic               out_zero,
   input  logic               clr_sticky,
   output logic               sticky_ovf,
   output logic [CNT_W-1:0]   done_count
);

   // ---- stage p0: combinational evaluation of the accepted request ----
   logic signed [31:0] z_p0;
   logic               equal_p0;
   logic               overflow_p0;
   logic               zero_p0;
   alu_result_t        res_p0;
   logic               vld_p0;
   logic               pop_p1;
   alu_result_t        head_p1;
   occ_t               occ_p1;
   logic [CNT_W-1:0]   done_p1;

   alu u_alu (
      .x        (in_x),
      .y        (in_y),
      .op       (in_op),
      .z        (z_p0),
      .equal    (equal_p0),
      .overflow (overflow_p0),
      .zero     (zero_p0)
   );

   assign res_p0 = '{z: z_p0, op: in_op, equal: equal_p0,
                     overflow: overflow_p0, zero: zero_p0};

   // in_ready depends only on registered occupancy, never on out_ready
   assign in_ready  = (occ_p1 != OCC_FULL);
   assign out_valid = (occ_p1 != OCC_EMPTY);
   assign vld_p0    = in_valid && in_ready;
   assign pop_p1    = out_valid && out_ready;

   // ---- stage p1: result buffer and head outputs ----
   alu_skid_buf #(
      .DEPTH (DEPTH)
   ) u_buf (
      .clk  (clk),
      .rst  (rst),
      .push (vld_p0),
      .pop  (pop_p1),
      .din  (res_p0),
      .head (head_p1),
      .occ  (occ_p1)
   );

   assign out_z        = head_p1.z;
   assign out_op       = head_p1.op;
   assign out_equal    = head_p1.equal;
   assign out_overflow = head_p1.overflow;
   assign out_zero     = head_p1.zero;

   // Completed-operation counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk) begin
      if (rst)
         done_p1 <= '0;
      else if (pop_p1)
         done_p1 <= done_p1 + CNT_W'(1);
   end

   assign done_count = done_p1;

`ifdef ALU_EXEC_STICKY_EN
   logic sticky_p1;

   // Sticky overflow: an overflowing push beats a same-cycle clear
   always_ff @(posedge clk) begin
      if (rst)
         sticky_p1 <= 1'b0;
      else if (vld_p0 && overflow_p0)
         sticky_p1 <= 1'b1;
      else if (clr_sticky)
         sticky_p1 <= 1'b0;
   end

   assign sticky_ovf = sticky_p1;
`else
   logic unused_clr_sticky;

   assign unused_clr_sticky = clr_sticky;
   assign sticky_ovf        = 1'b0;
`endif

endmodule
